// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the instruction realigner.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        ALIGNED      = 2'd0,
        MISALIGNED   = 2'd1,
        BRANCH_MISAL = 2'd2
    } realign_state_e;

    // Low two bits of an RV32 instruction; 2'b11 marks a full 32-bit encoding.
    localparam logic [1:0] OPCODE_C_MASK = 2'b11;

    // A halfword starts a compressed instruction unless both low bits are set.
    function automatic logic is_compressed(input logic [1:0] lsbs);
        return (lsbs & OPCODE_C_MASK) != OPCODE_C_MASK;
    endfunction

endpackage

// File: rtl/cv32e40p_instr_realigner.sv
// Turns the word-aligned prefetch stream into a halfword-aligned instruction
// stream (RV32C), one instruction per cycle, with a single stored halfword.
module cv32e40p_instr_realigner
    import cv32e40p_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_compressed_o,
    output logic [31:0] pc_o
);

    realign_state_e state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [15:0]    half_q, half_d;
    logic           accept;

    assign pc_o = pc_q;

    // Next-state and output selection; a branch overrides every state.
    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        half_d             = half_q;
        instr_valid_o      = 1'b0;
        fetch_ready_o      = 1'b0;
        instr_o            = fetch_rdata_i;
        instr_compressed_o = 1'b0;
        accept             = 1'b0;

        if (rst) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
        end else if (branch_i) begin
            pc_d    = branch_addr_i;
            state_d = branch_addr_i[1] ? BRANCH_MISAL : ALIGNED;
        end else begin
            unique case (state_q)
                ALIGNED: begin
                    instr_valid_o = fetch_valid_i;
                    accept        = instr_valid_o && instr_ready_i;
                    fetch_ready_o = accept;
                    if (is_compressed(fetch_rdata_i[1:0])) begin
                        instr_o            = {16'h0000, fetch_rdata_i[15:0]};
                        instr_compressed_o = 1'b1;
                        if (accept) begin
                            half_d  = fetch_rdata_i[31:16];
                            pc_d    = pc_q + 32'd2;
                            state_d = MISALIGNED;
                        end
                    end else begin
                        instr_o = fetch_rdata_i;
                        if (accept) begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end
                MISALIGNED: begin
                    if (is_compressed(half_q[1:0])) begin
                        instr_valid_o      = 1'b1;
                        accept             = instr_ready_i;
                        instr_o            = {16'h0000, half_q};
                        instr_compressed_o = 1'b1;
                        if (accept) begin
                            pc_d    = pc_q + 32'd2;
                            state_d = ALIGNED;
                        end
                    end else begin
                        instr_valid_o = fetch_valid_i;
                        accept        = instr_valid_o && instr_ready_i;
                        fetch_ready_o = accept;
                        instr_o       = {fetch_rdata_i[15:0], half_q};
                        if (accept) begin
                            half_d = fetch_rdata_i[31:16];
                            pc_d   = pc_q + 32'd4;
                        end
                    end
                end
                BRANCH_MISAL: begin
                    if (is_compressed(fetch_rdata_i[17:16])) begin
                        instr_valid_o      = fetch_valid_i;
                        accept             = instr_valid_o && instr_ready_i;
                        fetch_ready_o      = accept;
                        instr_o            = {16'h0000, fetch_rdata_i[31:16]};
                        instr_compressed_o = 1'b1;
                        if (accept) begin
                            pc_d    = pc_q + 32'd2;
                            state_d = ALIGNED;
                        end
                    end else begin
                        fetch_ready_o = fetch_valid_i;
                        if (fetch_valid_i) begin
                            half_d  = fetch_rdata_i[31:16];
                            state_d = MISALIGNED;
                        end
                    end
                end
                default: begin
                    state_d = ALIGNED;
                end
            endcase
        end
    end

    // State, PC and stored halfword registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALIGNED;
            pc_q    <= RESET_PC;
            half_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            half_q  <= half_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_instr_realigner.sv
// Directed self-checking bench for the instruction realigner.
module tb_cv32e40p_instr_realigner;

    logic        clk;
    logic        rst;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        instr_compressed_o;
    logic [31:0] pc_o;

    int errors = 0;
    int checks = 0;

    cv32e40p_instr_realigner #(.RESET_PC(32'h0000_0000)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_rdata_i      (fetch_rdata_i),
        .fetch_ready_o      (fetch_ready_o),
        .branch_i           (branch_i),
        .branch_addr_i      (branch_addr_i),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .instr_o            (instr_o),
        .instr_compressed_o (instr_compressed_o),
        .pc_o               (pc_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs and let combinational outputs settle.
    task automatic drive(input logic fv, input logic [31:0] word, input logic rdy,
                         input logic br, input logic [31:0] addr);
        fetch_valid_i = fv;
        fetch_rdata_i = word;
        instr_ready_i = rdy;
        branch_i      = br;
        branch_addr_i = addr;
        #2;
    endtask

    // Branch cycle: redirect and check nothing is issued or consumed.
    task automatic do_branch(input logic [31:0] addr);
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b1, addr);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL br_valid@%h: got %b expected 0", addr, instr_valid_o); end
        checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL br_fready@%h: got %b expected 0", addr, fetch_ready_o); end
        tick();
        checks++; if (pc_o !== addr) begin errors++; $display("FAIL br_pc: got %h expected %h", pc_o, addr); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid_o); end
        checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL rst_fready: got %b expected 0", fetch_ready_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", pc_o); end
        rst = 1'b0;
    endtask

    task automatic test_aligned_32();
        do_branch(32'h100);
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL a32_valid0: got %b expected 1", instr_valid_o); end
        checks++; if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL a32_instr0: got %h expected 00000013", instr_o); end
        checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL a32_pc0: got %h expected 100", pc_o); end
        checks++; if (instr_compressed_o !== 1'b0) begin errors++; $display("FAIL a32_comp0: got %b expected 0", instr_compressed_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL a32_fready0: got %b expected 1", fetch_ready_o); end
        tick();
        drive(1'b1, 32'h0010_0093, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_o !== 32'h0010_0093) begin errors++; $display("FAIL a32_instr1: got %h expected 00100093", instr_o); end
        checks++; if (pc_o !== 32'h104) begin errors++; $display("FAIL a32_pc1: got %h expected 104", pc_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL a32_fready1: got %b expected 1", fetch_ready_o); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (pc_o !== 32'h108) begin errors++; $display("FAIL a32_pc2: got %h expected 108", pc_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL a32_idle_valid: got %b expected 0", instr_valid_o); end
    endtask

    task automatic test_compressed_pair();
        do_branch(32'h200);
        drive(1'b1, 32'h4505_4501, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_o !== 32'h0000_4501) begin errors++; $display("FAIL cp_instr0: got %h expected 00004501", instr_o); end
        checks++; if (instr_compressed_o !== 1'b1) begin errors++; $display("FAIL cp_comp0: got %b expected 1", instr_compressed_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL cp_fready0: got %b expected 1", fetch_ready_o); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL cp_valid1: got %b expected 1", instr_valid_o); end
        checks++; if (instr_o !== 32'h0000_4505) begin errors++; $display("FAIL cp_instr1: got %h expected 00004505", instr_o); end
        checks++; if (pc_o !== 32'h202) begin errors++; $display("FAIL cp_pc1: got %h expected 202", pc_o); end
        checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL cp_fready1: got %b expected 0", fetch_ready_o); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (pc_o !== 32'h204) begin errors++; $display("FAIL cp_pc2: got %h expected 204", pc_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL cp_aligned_valid: got %b expected 0", instr_valid_o); end
    endtask

    task automatic test_straddle();
        do_branch(32'h0);
        drive(1'b1, 32'h0093_4501, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_o !== 32'h0000_4501) begin errors++; $display("FAIL st_instr0: got %h expected 00004501", instr_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL st_pc0: got %h expected 0", pc_o); end
        tick();
        drive(1'b1, 32'h0010_0001, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_o !== 32'h0001_0093) begin errors++; $display("FAIL st_instr1: got %h expected 00010093", instr_o); end
        checks++; if (pc_o !== 32'h2) begin errors++; $display("FAIL st_pc1: got %h expected 2", pc_o); end
        checks++; if (instr_compressed_o !== 1'b0) begin errors++; $display("FAIL st_comp1: got %b expected 0", instr_compressed_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL st_fready1: got %b expected 1", fetch_ready_o); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (pc_o !== 32'h6) begin errors++; $display("FAIL st_pc2: got %h expected 6", pc_o); end
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL st_valid2: got %b expected 1", instr_valid_o); end
        checks++; if (instr_o !== 32'h0000_0010) begin errors++; $display("FAIL st_instr2: got %h expected 00000010", instr_o); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (pc_o !== 32'h8) begin errors++; $display("FAIL st_pc3: got %h expected 8", pc_o); end
    endtask

    task automatic test_branch_misal();
        do_branch(32'h302);
        drive(1'b1, 32'h0093_1234, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL bm_valid0: got %b expected 0", instr_valid_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL bm_fready0: got %b expected 1", fetch_ready_o); end
        tick();
        drive(1'b1, 32'hAAAA_0010, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL bm_valid1: got %b expected 1", instr_valid_o); end
        checks++; if (instr_o !== 32'h0010_0093) begin errors++; $display("FAIL bm_instr1: got %h expected 00100093", instr_o); end
        checks++; if (pc_o !== 32'h302) begin errors++; $display("FAIL bm_pc1: got %h expected 302", pc_o); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_o !== 32'h0000_AAAA) begin errors++; $display("FAIL bm_instr2: got %h expected 0000aaaa", instr_o); end
        checks++; if (pc_o !== 32'h306) begin errors++; $display("FAIL bm_pc2: got %h expected 306", pc_o); end
        do_branch(32'h402);
        drive(1'b1, 32'h4509_0000, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_o !== 32'h0000_4509) begin errors++; $display("FAIL bmc_instr: got %h expected 00004509", instr_o); end
        checks++; if (instr_compressed_o !== 1'b1) begin errors++; $display("FAIL bmc_comp: got %b expected 1", instr_compressed_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL bmc_fready: got %b expected 1", fetch_ready_o); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (pc_o !== 32'h404) begin errors++; $display("FAIL bmc_pc: got %h expected 404", pc_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL bmc_aligned_valid: got %b expected 0", instr_valid_o); end
    endtask

    task automatic test_branch_priority();
        do_branch(32'h800);
        drive(1'b1, 32'h4505_4501, 1'b1, 1'b0, 32'h0);
        tick();
        // Compressed 0x4505 now pending; a branch must drop it.
        do_branch(32'h600);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL bp_discard_valid: got %b expected 0", instr_valid_o); end
    endtask

    task automatic test_stall_reset();
        do_branch(32'h700);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h0);
            checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b expected 1", i, instr_valid_o); end
            checks++; if (instr_o !== 32'h0010_0093) begin errors++; $display("FAIL stall_instr%0d: got %h expected 00100093", i, instr_o); end
            checks++; if (pc_o !== 32'h700) begin errors++; $display("FAIL stall_pc%0d: got %h expected 700", i, pc_o); end
            checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL stall_fready%0d: got %b expected 0", i, fetch_ready_o); end
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 32'h0010_0093, 1'b1, 1'b1, 32'h0000_0900);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", instr_valid_o); end
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h expected 0", pc_o); end
    endtask

    task automatic test_wrap();
        do_branch(32'hFFFF_FFFE);
        drive(1'b1, 32'h4501_0000, 1'b1, 1'b0, 32'h0);
        checks++; if (instr_o !== 32'h0000_4501) begin errors++; $display("FAIL wrap_instr: got %h expected 00004501", instr_o); end
        checks++; if (pc_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_pc0: got %h expected fffffffe", pc_o); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h expected 0", pc_o); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst           = 1'b1;
        fetch_valid_i = 1'b0;
        fetch_rdata_i = 32'h0;
        instr_ready_i = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        test_reset();
        test_aligned_32();
        test_compressed_pair();
        test_straddle();
        test_branch_misal();
        test_branch_priority();
        test_stall_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
